// File: rtl/ps2_key_rx_pkg.sv
// Shared constants, decoder state encoding and key event layout for the PS/2 key receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_E0         = 8'hE0;
  localparam logic [7:0] PS2_F0         = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;
  localparam int         PS2_EVENT_W    = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EXT     = 2'b01,
    BRK     = 2'b10,
    EXT_BRK = 2'b11
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// Valid/ready key event stream between the PS/2 receiver and its consumer.
interface ps2_key_rx_if;

  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;

  modport master (
    output key_valid,
    output key_code,
    output key_break,
    output key_ext,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_break,
    input  key_ext,
    output key_ready
  );

endinterface

// File: rtl/ps2_key_rx_fifo.sv
// Synchronous first-word-fall-through FIFO holding decoded key events.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: pin sync/filter, 11-bit framer, E0/F0 prefix decoder, event FIFO.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ps_clk,
  input  logic           ps_data,
  ps2_key_rx_if.master   key,
  output logic           parity_err,
  output logic           frame_err,
  output logic           overflow
);

  localparam int                FILT_W    = $clog2(FILTER_LEN + 1);
  localparam int                TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;
  logic                   clk_filt;
  logic [FILT_W-1:0]      filt_cnt;
  logic                   flip;
  logic                   fall;
  logic [3:0]             bit_idx;
  logic [9:0]             frame;
  logic [TO_W-1:0]        to_cnt;
  logic                   byte_valid;
  logic [7:0]             byte_data;
  dec_state_t             dec_state;
  dec_state_t             dec_next;
  logic                   emit;
  key_event_t             ev;
  logic                   push_q;
  key_event_t             push_ev;
  logic [PS2_EVENT_W-1:0] head;
  logic                   fifo_empty;
  logic                   fifo_full;

  // Idle PS/2 bus is high, so the synchronisers come out of reset at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps_data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign flip   = (clk_s != clk_filt) && (filt_cnt == FILT_LAST);
  assign fall   = flip && clk_filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == clk_filt) begin
      filt_cnt <= '0;
    end else if (flip) begin
      clk_filt <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // The stop bit is checked straight from the pin, so only bits 0..9 are stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx    <= '0;
      frame      <= '0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        if (bit_idx == LAST_BIT) begin
          bit_idx <= '0;
          if (frame[0] || !data_s) begin
            frame_err <= 1'b1;
          end else if (!odd_parity_ok(frame[8:1], frame[9])) begin
            parity_err <= 1'b1;
          end else begin
            byte_valid <= 1'b1;
            byte_data  <= frame[8:1];
          end
        end else begin
          frame[bit_idx] <= data_s;
          bit_idx        <= bit_idx + 1'b1;
        end
      end else if (bit_idx != '0) begin
        if (to_cnt == TO_LAST) begin
          bit_idx   <= '0;
          to_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dec_state <= IDLE;
    else     dec_state <= dec_next;
  end

  always_comb begin
    dec_next = dec_state;
    if (parity_err || frame_err) begin
      dec_next = IDLE;
    end else if (byte_valid) begin
      case (dec_state)
        IDLE:    dec_next = (byte_data == PS2_E0) ? EXT :
                            (byte_data == PS2_F0) ? BRK : IDLE;
        EXT:     dec_next = (byte_data == PS2_E0) ? EXT :
                            (byte_data == PS2_F0) ? EXT_BRK : IDLE;
        BRK:     dec_next = (byte_data == PS2_E0) ? EXT_BRK :
                            (byte_data == PS2_F0) ? BRK : IDLE;
        EXT_BRK: dec_next = (byte_data == PS2_E0 || byte_data == PS2_F0) ? EXT_BRK : IDLE;
        default: dec_next = IDLE;
      endcase
    end
  end

  always_comb begin
    emit    = byte_valid && (byte_data != PS2_E0) && (byte_data != PS2_F0);
    ev.ext  = (dec_state == EXT) || (dec_state == EXT_BRK);
    ev.brk  = (dec_state == BRK) || (dec_state == EXT_BRK);
    ev.code = byte_data;
  end

  // Events are staged one cycle before the FIFO; overflow is flagged from that stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_q   <= 1'b0;
      push_ev  <= '0;
      overflow <= 1'b0;
    end else begin
      push_q   <= emit;
      push_ev  <= ev;
      overflow <= push_q && fifo_full && !(!fifo_empty && key.key_ready);
    end
  end

  ps2_event_fifo #(
    .WIDTH (PS2_EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_ev),
    .pop       (key.key_ready),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign key.key_valid = !fifo_empty;
  assign key.key_code  = head[7:0];
  assign key.key_break = head[8];
  assign key.key_ext   = head[9];

endmodule
